onchip_mem_burst_adapter: RTL and testbench

Avalon-MM burst adapter placed directly upstream of the on-chip 64000×32 single-port RAM slave. It accepts pipelined read/write bursts from the system interconnect and expands them into one single-word RAM access per cycle. It tracks the RAM's fixed one-cycle read latency and returns data with `readdatavalid` and a per-beat response code. This lets bursting masters such as DMA and video frame readers use the RAM without an interconnect burst converter.

---
 rtl/onchip_mem_pkg.sv | 17 +
 rtl/onchip_mem_rdv_pipe.sv | 37 +++
 rtl/onchip_mem_burst_adapter.sv | 202 ++++++++++++++++++++
 tb/tb_onchip_mem_burst_adapter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip RAM burst adapter.
package onchip_mem_pkg;

    // Adapter FSM encoding (plain constants so older tools can consume it)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;

    // Avalon-MM response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Data returned for a read beat that falls outside the implemented RAM
    localparam logic [31:0] BAD_READ_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/onchip_mem_rdv_pipe.sv
// Read-valid tracking pipe: RD_LAT-deep shift register of {valid, response},
// aligned with the RAM's fixed read latency.
module onchip_mem_rdv_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_valid_i,
    input  logic [1:0] push_resp_i,
    output logic       pop_valid_o,
    output logic [1:0] pop_resp_o
);

    logic [RD_LAT-1:0]      valid_q, valid_d;
    logic [RD_LAT-1:0][1:0] resp_q, resp_d;

    // Shift one stage per cycle; the oldest entry falls off the top
    always_comb begin
        valid_d = RD_LAT'({valid_q, push_valid_i});
        resp_d  = (2 * RD_LAT)'({resp_q, push_resp_i});
    end

    // Pipe state, cleared synchronously so in-flight beats are discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            resp_q  <= '0;
        end else begin
            valid_q <= valid_d;
            resp_q  <= resp_d;
        end
    end

    assign pop_valid_o = valid_q[RD_LAT-1];
    assign pop_resp_o  = resp_q[RD_LAT-1];

endmodule

// File: rtl/onchip_mem_burst_adapter.sv
// Avalon-MM burst adapter in front of a single-port on-chip RAM.
// Expands read/write bursts into one RAM access per cycle and returns read
// data with readdatavalid and a response code.
// Optional: define ONCHIP_MEM_RANGE_CHECK_EN to flag beats addressing words
// at or beyond DEPTH (writes suppressed, reads return BAD_READ_WORD/SLVERR).
module onchip_mem_burst_adapter
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 64000,
    parameter int unsigned BURST_W = 7,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [1:0]          s_response,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);

`ifdef ONCHIP_MEM_RANGE_CHECK_EN
    localparam logic RangeChk = 1'b1;
`else
    localparam logic RangeChk = 1'b0;
`endif
    // One extra bit so DEPTH == 2^ADDR_W still compares correctly
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic                 wr_cs_q, wr_cs_d;
    logic                 wr_we_q, wr_we_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W/8-1:0]  wr_be_q, wr_be_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;

    logic [BURST_W-1:0]   req_cnt;
    logic                 wr_beat;
    logic [ADDR_W-1:0]    wr_beat_addr;
    logic                 wr_bad;
    logic                 rd_bad;
    logic                 rd_issue;
    logic [1:0]           rd_resp;
    logic                 pop_valid;
    logic [1:0]           pop_resp;

    assign req_cnt  = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
    assign rd_bad   = RangeChk && ({1'b0, addr_q} >= DepthLim);
    assign rd_issue = (state_q == ST_RD) && !reset;
    assign rd_resp  = (rd_issue && rd_bad) ? RESP_SLVERR : RESP_OKAY;

    // Command acceptance, burst address/count tracking and write-beat capture
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        wr_cs_d      = 1'b0;
        wr_we_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_be_d      = wr_be_q;
        wr_data_d    = wr_data_q;
        wr_beat      = 1'b0;
        wr_beat_addr = addr_q;
        wr_bad       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_read) begin
                    addr_d  = s_address;
                    cnt_d   = req_cnt;
                    state_d = ST_RD;
                end else if (s_write) begin
                    // First beat rides with the command
                    wr_beat      = 1'b1;
                    wr_beat_addr = s_address;
                    addr_d       = s_address + 1'b1;
                    cnt_d        = req_cnt - 1'b1;
                    if (req_cnt != BURST_W'(1)) begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == BURST_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                // Cycles without s_write keep the burst open
                if (s_write) begin
                    wr_beat = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_beat) begin
            wr_bad    = RangeChk && ({1'b0, wr_beat_addr} >= DepthLim);
            wr_cs_d   = !wr_bad;
            wr_we_d   = !wr_bad;
            wr_addr_d = wr_beat_addr;
            wr_be_d   = s_byteenable;
            wr_data_d = s_writedata;
        end
    end

    // Control state and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_cs_q   <= 1'b0;
            wr_we_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_cs_q   <= wr_cs_d;
            wr_we_q   <= wr_we_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            wr_data_q <= wr_data_d;
        end
    end

    onchip_mem_rdv_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rdv_pipe (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (rd_issue),
        .push_resp_i  (rd_resp),
        .pop_valid_o  (pop_valid),
        .pop_resp_o   (pop_resp)
    );

    // RAM port mux: reads drive straight from the burst counter so the
    // first access lands one cycle after acceptance; writes come from the
    // registered beat. A write is never pending while in ST_RD.
    always_comb begin
        m_address    = wr_addr_q;
        m_byteenable = wr_be_q;
        m_chipselect = wr_cs_q;
        m_write      = wr_we_q;
        m_writedata  = wr_data_q;
        if (state_q == ST_RD) begin
            m_address    = addr_q;
            m_byteenable = '1;
            m_chipselect = !rd_bad;
            m_write      = 1'b0;
        end
        if (reset) begin
            m_address    = '0;
            m_byteenable = '0;
            m_chipselect = 1'b0;
            m_write      = 1'b0;
            m_writedata  = '0;
        end
    end

    // Slave-side response: data is only presented alongside readdatavalid
    always_comb begin
        s_waitrequest   = reset || (state_q == ST_RD);
        s_readdatavalid = pop_valid && !reset;
        s_response      = RESP_OKAY;
        s_readdata      = '0;
        if (s_readdatavalid) begin
            s_response = pop_resp;
            s_readdata = (pop_resp == RESP_SLVERR) ? DATA_W'(BAD_READ_WORD) : m_readdata;
        end
    end

    assign m_clken = !reset;

endmodule

// File: tb/tb_onchip_mem_burst_adapter.sv
// Directed bench for onchip_mem_burst_adapter with a behavioural 1-cycle RAM.
module tb_onchip_mem_burst_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_address;
    logic [6:0]  s_burstcount;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [1:0]  s_response;
    logic [15:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic [31:0] m_readdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    onchip_mem_burst_adapter dut (
        .clk             (clk),
        .reset           (reset),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_response      (s_response),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    // RAM model: registered read (1 cycle), byte-enabled write; preloaded in reset
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (reset) begin
            mem[16'h0010] <= 32'h12345678;
            mem[16'h0100] <= 32'hB0000100;
            mem[16'h0101] <= 32'hB0000101;
            mem[16'h0102] <= 32'hB0000102;
            mem[16'h0103] <= 32'hB0000103;
            mem[16'h0202] <= 32'h77777777;
            mem[16'hFFFF] <= 32'h0F0F0F0F;
            mem[16'h0000] <= 32'h13579BDF;
            m_readdata    <= 32'h0;
        end else if (m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
                end
            end else begin
                m_readdata <= mem[m_address];
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [6:0]  cnt;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = 16'h0;
        s_burstcount = 7'd0;
        s_writedata  = 32'h0;
        s_byteenable = 4'h0;
    endtask

    task automatic read1(input string name, input logic [15:0] addr, input logic [31:0] exp);
        s_read       = 1'b1;
        s_address    = addr;
        s_burstcount = 7'd1;
        tick();
        idle_in();
        tick();
        chk({name, "_valid"}, s_readdatavalid, 1);
        chk({name, "_data"}, s_readdata, exp);
        tick();
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] be);
        s_write      = 1'b1;
        s_writedata  = d;
        s_byteenable = be;
    endtask

    initial begin
        int          wreq_hi;
        int          nvalid;
        int          ncs;
        logic        exp_cs1;
        logic [31:0] exp_d1;
        logic [1:0]  exp_r1;

        vecs[0] = '{1'b1, 16'h0020, 7'd1, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00};
        vecs[1] = '{1'b0, 16'h0020, 7'd1, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00};
        vecs[2] = '{1'b1, 16'h0020, 7'd1, 32'h11223344, 4'b0100, 32'h0, 2'b00};
        vecs[3] = '{1'b0, 16'h0020, 7'd1, 32'h0, 4'h0, 32'hCA22F00D, 2'b00};
        vecs[4] = '{1'b0, 16'h0010, 7'd1, 32'h0, 4'h0, 32'h12345678, 2'b00};
        vecs[5] = '{1'b1, 16'h0005, 7'd0, 32'h00000055, 4'hF, 32'h0, 2'b00};
        vecs[6] = '{1'b0, 16'h0005, 7'd0, 32'h0, 4'h0, 32'h00000055, 2'b00};

        idle_in();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_waitreq", s_waitrequest, 1);
        chk("rst_rdv", s_readdatavalid, 0);
        chk("rst_rdata", s_readdata, 0);
        chk("rst_resp", s_response, 0);
        chk("rst_cs", m_chipselect, 0);
        chk("rst_we", m_write, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_be", m_byteenable, 0);
        chk("rst_wdata", m_writedata, 0);
        chk("rst_clken", m_clken, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_waitreq", s_waitrequest, 0);
        chk("post_rst_clken", m_clken, 1);
        tick();

        // Single-beat table: command at T, RAM access at T+1, read data at T+2
        for (int i = 0; i < 7; i++) begin
            vec_t v;
            v = vecs[i];
            chk($sformatf("vec%0d_idle_wreq", i), s_waitrequest, 0);
            s_address    = v.addr;
            s_burstcount = v.cnt;
            s_writedata  = v.wdata;
            s_byteenable = v.be;
            s_read       = !v.wr;
            s_write      = v.wr;
            tick();
            idle_in();
            chk($sformatf("vec%0d_cs", i), m_chipselect, 1);
            chk($sformatf("vec%0d_we", i), m_write, v.wr);
            chk($sformatf("vec%0d_addr", i), m_address, v.addr);
            if (v.wr) begin
                chk($sformatf("vec%0d_wdata", i), m_writedata, v.wdata);
                chk($sformatf("vec%0d_be", i), m_byteenable, v.be);
            end else begin
                chk($sformatf("vec%0d_busy", i), s_waitrequest, 1);
            end
            tick();
            chk($sformatf("vec%0d_wreq_after", i), s_waitrequest, 0);
            if (v.wr) begin
                chk($sformatf("vec%0d_one_write", i), m_chipselect, 0);
            end else begin
                chk($sformatf("vec%0d_rdv", i), s_readdatavalid, 1);
                chk($sformatf("vec%0d_rdata", i), s_readdata, v.exp_data);
                chk($sformatf("vec%0d_resp", i), s_response, v.exp_resp);
            end
            tick();
            chk($sformatf("vec%0d_rdv_end", i), s_readdatavalid, 0);
        end

        // 4-beat read at 0x0100
        s_read       = 1'b1;
        s_address    = 16'h0100;
        s_burstcount = 7'd4;
        tick();
        idle_in();
        wreq_hi = 0;
        for (int c = 1; c <= 6; c++) begin
            if (s_waitrequest) wreq_hi++;
            if (c <= 4) begin
                chk($sformatf("b4_cs_c%0d", c), m_chipselect, 1);
                chk($sformatf("b4_addr_c%0d", c), m_address, 32'h0100 + c - 1);
            end else begin
                chk($sformatf("b4_cs_c%0d", c), m_chipselect, 0);
            end
            if (c >= 2 && c <= 5) begin
                chk($sformatf("b4_rdv_c%0d", c), s_readdatavalid, 1);
                chk($sformatf("b4_data_c%0d", c), s_readdata, 32'hB0000100 + c - 2);
            end else begin
                chk($sformatf("b4_rdv_c%0d", c), s_readdatavalid, 0);
            end
            tick();
        end
        chk("b4_wreq_cycles", wreq_hi, 4);

        // 3-beat write at 0x0200 with a gap after beat 2, beat 3 low half only
        s_address    = 16'h0200;
        s_burstcount = 7'd3;
        wbeat(32'hA1A1A1A1, 4'hF);
        tick();
        chk("wb_b1_cs", m_chipselect & m_write, 1);
        chk("wb_b1_addr", m_address, 16'h0200);
        chk("wb_b1_wreq", s_waitrequest, 0);
        s_address = 16'h0;
        wbeat(32'hB2B2B2B2, 4'hF);
        tick();
        chk("wb_b2_cs", m_chipselect & m_write, 1);
        chk("wb_b2_addr", m_address, 16'h0201);
        idle_in();
        tick();
        chk("wb_gap_cs", m_chipselect, 0);
        chk("wb_gap_wreq", s_waitrequest, 0);
        wbeat(32'hC3C3C3C3, 4'b0011);
        tick();
        idle_in();
        chk("wb_b3_cs", m_chipselect & m_write, 1);
        chk("wb_b3_addr", m_address, 16'h0202);
        chk("wb_b3_be", m_byteenable, 4'b0011);
        tick();
        chk("wb_done_cs", m_chipselect, 0);
        read1("wb_rb0", 16'h0200, 32'hA1A1A1A1);
        read1("wb_rb1", 16'h0201, 32'hB2B2B2B2);
        read1("wb_rb2", 16'h0202, 32'h7777C3C3);

        // Wrap read: 0xFFFF then 0x0000
`ifdef ONCHIP_MEM_RANGE_CHECK_EN
        exp_cs1 = 1'b0;
        exp_d1  = 32'hDEADBEEF;
        exp_r1  = 2'b10;
`else
        exp_cs1 = 1'b1;
        exp_d1  = 32'h0F0F0F0F;
        exp_r1  = 2'b00;
`endif
        s_read       = 1'b1;
        s_address    = 16'hFFFF;
        s_burstcount = 7'd2;
        tick();
        idle_in();
        chk("wrap_addr1", m_address, 16'hFFFF);
        chk("wrap_cs1", m_chipselect, exp_cs1);
        tick();
        chk("wrap_addr2", m_address, 16'h0000);
        chk("wrap_cs2", m_chipselect, 1);
        chk("wrap_rdv1", s_readdatavalid, 1);
        chk("wrap_data1", s_readdata, exp_d1);
        chk("wrap_resp1", s_response, exp_r1);
        tick();
        chk("wrap_rdv2", s_readdatavalid, 1);
        chk("wrap_data2", s_readdata, 32'h13579BDF);
        chk("wrap_resp2", s_response, 2'b00);
        tick();
        chk("wrap_rdv_end", s_readdatavalid, 0);

        // Reset in the middle of an 8-beat read, after three issues
        s_read       = 1'b1;
        s_address    = 16'h0300;
        s_burstcount = 7'd8;
        tick();
        idle_in();
        tick();
        tick();
        chk("mrst_issue3_addr", m_address, 16'h0302);
        chk("mrst_issue3_cs", m_chipselect, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_in_rdv", s_readdatavalid, 0);
        chk("mrst_in_cs", m_chipselect, 0);
        chk("mrst_in_wreq", s_waitrequest, 1);
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_post_wreq", s_waitrequest, 0);
        chk("mrst_post_clken", m_clken, 1);
        nvalid = 0;
        ncs    = 0;
        for (int c = 0; c < 10; c++) begin
            if (s_readdatavalid) nvalid++;
            if (m_chipselect) ncs++;
            tick();
        end
        chk("mrst_no_rdv", nvalid, 0);
        chk("mrst_no_access", ncs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
